spi_ram_arbiter: RTL
====================

// Module: spi_ram_arbiter
// PURPOSE
//  Shares one word-addressed SPI RAM controller (strobe/busy interface) between two masters:
//  m0 = FemtoRV32 CPU data port, m1 = secondary master (UART loader / DMA).
//  Latches one strobed request per port, grants one at a time and drives the slave with one strobe.
//  Returns read data and busy to the owning port only. Sits between the address decoder and the SPI RAM controller.
// PARAMETERS
//  AW  20  word-address width (byte address bits [21:2])
//  DW  32  data width
// PORTS
//  clk        in   1   system clock
//  resetn     in   1   asynchronous active-low reset
//  mN_addr    in   AW  port N word address, N=0,1; sampled on strobe
//  mN_wdata   in   DW  port N write data; sampled on mN_wr
//  mN_rd      in   1   port N one-cycle read strobe
//  mN_wr      in   1   port N one-cycle write strobe
//  mN_rdata   out  DW  port N read data; valid once mN_rbusy falls, held until next read completes
//  mN_rbusy   out  1   port N read pending
//  mN_wbusy   out  1   port N write pending
//  s_addr     out  AW  slave word address (registered)
//  s_wdata    out  DW  slave write data (registered)
//  s_rd       out  1   slave read strobe, exactly one cycle
//  s_wr       out  1   slave write strobe, exactly one cycle
//  s_rdata    in   DW  slave read data, valid when s_rbusy low after a read
//  s_rbusy    in   1   slave read busy; high from cycle after s_rd until done
//  s_wbusy    in   1   slave write busy; high from cycle after s_wr until done
//  grant      out  2   one-hot current owner; 00 when idle
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, both pending slots empty, last_grant = m1 (m0 first under RR).
//  Capture: strobe sets pending slot (op, addr, wdata) at the clock edge.
//   mN_rbusy / mN_wbusy go high the next cycle and stay high until completion.
//   If rd and wr fire together, the request is a write.
//   A strobe on a port with a pending slot is ignored (protocol violation; no state change).
//  FSM:
//   IDLE: any slot pending -> pick winner, load s_addr/s_wdata, set grant -> ISSUE.
//    A strobe arriving this same cycle is eligible next cycle, not this one.
//   ISSUE: assert s_rd or s_wr for exactly 1 cycle -> WAIT.
//   WAIT: while (s_rbusy | s_wbusy) stay.
//    When both are low: on read, copy s_rdata -> mN_rdata; clear slot; deassert mN busy (registered) -> IDLE.
//    Never exit WAIT in the cycle immediately after ISSUE; always sample busy there first.
//  Latency: strobe to slave strobe = 2 cycles when idle. Busy drop = slave done + 1 cycle.
//  Back-to-back: IDLE -> ISSUE for the other pending port immediately, with no dead cycle beyond IDLE.
//  Both strobed in the same cycle: both latched, winner per arbitration policy, loser waits in slot.
//  Non-owning port: its rdata/busy are unaffected by slave activity.
//  Reset mid-transfer: FSM/slots cleared asynchronously, strobes drop; slave controller must share resetn.
// CONFIGURATION
//  SPI_RAM_ARB_RR_EN defined:
//   round-robin; when both pending, grant the port not in last_grant; last_grant updates on each grant.
//  Undefined:
//   fixed priority, m0 (CPU) always wins when both pending; m1 can starve under continuous CPU traffic.
// TESTING
//  m0_rd addr=0x00010, slave busy 5 cycles, s_rdata=0xDEADBEEF:
//   s_rd one cycle at +2; m0_rbusy high +1..done; m0_rdata=0xDEADBEEF.
//  m1_wr addr=0x00020 wdata=0x12345678:
//   s_wr one cycle, s_addr=0x00020, s_wdata=0x12345678; m1_wbusy clears; m0 outputs untouched.
//  m0_rd and m1_wr in the same cycle:
//   fixed -> m0 first, m1 issued right after m0 completes.
//   RR with last_grant=m0 -> m1 first.
//  Continuous m0 reads with m1 pending:
//   RR -> grants alternate m0,m1,m0.
//   fixed -> m1 waits until m0 idle.
//  Second m0_rd while m0_rbusy is high -> ignored; exactly one s_rd; no rdata corruption.
//  resetn low during WAIT -> all outputs 0 within the same cycle; after release, a new m1_rd completes normally.

Source files
------------

// File: rtl/spi_ram_arbiter.sv
// Two-master arbiter in front of a strobe/busy SPI RAM controller (m0 = CPU, m1 = loader/DMA).
// Define SPI_RAM_ARB_RR_EN for round-robin arbitration; otherwise m0 has fixed priority.
module spi_ram_arbiter #(
  parameter int AW = 20,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic          m0_rd,
  input  logic          m0_wr,
  output logic [DW-1:0] m0_rdata,
  output logic          m0_rbusy,
  output logic          m0_wbusy,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  input  logic          m1_rd,
  input  logic          m1_wr,
  output logic [DW-1:0] m1_rdata,
  output logic          m1_rbusy,
  output logic          m1_wbusy,
  output logic [AW-1:0] s_addr,
  output logic [DW-1:0] s_wdata,
  output logic          s_rd,
  output logic          s_wr,
  input  logic [DW-1:0] s_rdata,
  input  logic          s_rbusy,
  input  logic          s_wbusy,
  output logic [1:0]    grant
);

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } state_t;

  state_t        state;
  logic          owner;
  logic          settle;
  logic          winner;
  logic          done;

  logic [1:0]    strobe_rd;
  logic [1:0]    strobe_wr;
  logic [AW-1:0] req_addr   [2];
  logic [DW-1:0] req_wdata  [2];

  logic [1:0]    pend;
  logic [1:0]    pend_wr;
  logic [AW-1:0] slot_addr  [2];
  logic [DW-1:0] slot_wdata [2];
  logic [1:0]    rbusy;
  logic [1:0]    wbusy;
  logic [DW-1:0] rdata      [2];

`ifdef SPI_RAM_ARB_RR_EN
  logic          last_grant;
`endif

  assign strobe_rd    = {m1_rd, m0_rd};
  assign strobe_wr    = {m1_wr, m0_wr};
  assign req_addr[0]  = m0_addr;
  assign req_addr[1]  = m1_addr;
  assign req_wdata[0] = m0_wdata;
  assign req_wdata[1] = m1_wdata;

  assign m0_rdata = rdata[0];
  assign m1_rdata = rdata[1];
  assign m0_rbusy = rbusy[0];
  assign m1_rbusy = rbusy[1];
  assign m0_wbusy = wbusy[0];
  assign m1_wbusy = wbusy[1];

  // Winner is only meaningful in IDLE when at least one slot is pending.
  always_comb begin
    winner = ~pend[0];
`ifdef SPI_RAM_ARB_RR_EN
    if (pend == 2'b11) winner = ~last_grant;
`endif
  end

  // settle masks the first WAIT cycle, where the slave has not yet raised busy.
  assign done = (state == WAIT) && !settle && !s_rbusy && !s_wbusy;

  // Per-port request slots; a strobe on an occupied slot is dropped.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      pend    <= '0;
      pend_wr <= '0;
      rbusy   <= '0;
      wbusy   <= '0;
      for (int i = 0; i < 2; i++) begin
        slot_addr[i]  <= '0;
        slot_wdata[i] <= '0;
        rdata[i]      <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        if (done && (owner == i[0])) begin
          pend[i]  <= 1'b0;
          rbusy[i] <= 1'b0;
          wbusy[i] <= 1'b0;
          if (!pend_wr[i]) rdata[i] <= s_rdata;
        end else if (!pend[i] && (strobe_rd[i] || strobe_wr[i])) begin
          pend[i]      <= 1'b1;
          pend_wr[i]   <= strobe_wr[i];
          slot_addr[i] <= req_addr[i];
          rbusy[i]     <= ~strobe_wr[i];
          wbusy[i]     <= strobe_wr[i];
          if (strobe_wr[i]) slot_wdata[i] <= req_wdata[i];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      owner   <= 1'b0;
      settle  <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      s_rd    <= 1'b0;
      s_wr    <= 1'b0;
      grant   <= 2'b00;
`ifdef SPI_RAM_ARB_RR_EN
      last_grant <= 1'b1;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (|pend) begin
            owner   <= winner;
            s_addr  <= slot_addr[winner];
            s_wdata <= slot_wdata[winner];
            grant   <= winner ? 2'b10 : 2'b01;
`ifdef SPI_RAM_ARB_RR_EN
            last_grant <= winner;
`endif
            state   <= ISSUE;
          end
        end
        ISSUE: begin
          s_rd   <= ~pend_wr[owner];
          s_wr   <= pend_wr[owner];
          settle <= 1'b1;
          state  <= WAIT;
        end
        WAIT: begin
          s_rd   <= 1'b0;
          s_wr   <= 1'b0;
          settle <= 1'b0;
          if (done) begin
            grant <= 2'b00;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
